// File: rtl/mdu_unit.sv
// Multiply/divide unit for the E stage: owns HI/LO, models multi-cycle
// mult/div latency with a down-counter and reports busy to the stall logic.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] mdu_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } mdu_op_e;

  mdu_op_e op;
  assign op = mdu_op_e'(MDUOp);

  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  // Product: sign- or zero-extend to 64 bits; the low 64 bits of the
  // extended product are exact for both signed and unsigned operands.
  logic [63:0] prod_s, prod_u;
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Division on magnitudes, then restore signs: quotient truncates toward
  // zero and the remainder follows the dividend. 0x80000000 / -1 falls out
  // naturally as quotient 0x80000000, remainder 0.
  logic        signed_div;
  logic [31:0] dvd, dvs, dvs_safe, q_mag, r_mag, quot, rem;
  logic        div_by_zero;

  assign signed_div  = (op == OP_DIV);
  assign dvd         = (signed_div && A[31]) ? (32'd0 - A) : A;
  assign dvs         = (signed_div && B[31]) ? (32'd0 - B) : B;
  assign div_by_zero = (B == 32'd0);
  assign dvs_safe    = div_by_zero ? 32'd1 : dvs;
  assign q_mag       = dvd / dvs_safe;
  assign r_mag       = dvd % dvs_safe;
  assign quot        = (signed_div && (A[31] ^ B[31])) ? (32'd0 - q_mag) : q_mag;
  assign rem         = (signed_div && A[31]) ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    // NOTE: every _d starts at its _q so no path through the branches below
    // leaves a signal unassigned, which would otherwise infer a latch.
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    cnt_d     = cnt_q;

    if (cnt_q != '0) begin
      // In flight: req and new ops are ignored; the result retires on 1->0.
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE && pend_wr_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (!req) begin
      unique case (op)
        OP_MULT, OP_MULTU: begin
          if (start) begin
            {pend_hi_d, pend_lo_d} = (op == OP_MULT) ? prod_s : prod_u;
            pend_wr_d = 1'b1;
            cnt_d     = MULT_LOAD;
          end
        end
        OP_DIV, OP_DIVU: begin
          if (start) begin
            pend_hi_d = rem;
            pend_lo_d = quot;
            pend_wr_d = !div_by_zero;
            cnt_d     = DIV_LOAD;
          end
        end
        OP_MTHI: hi_d = A;
        OP_MTLO: lo_d = A;
        default: ;
      endcase
    end

    busy_d = (cnt_d != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its _d regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: pending results are reset too, so a reset mid-operation can
      // never retire a stale value after release.
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign HI      = hi_q;
  assign LO      = lo_q;
  assign mdu_out = (op == OP_MFHI) ? hi_q : lo_q;

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage of the P7 pipeline.
- Consumes the E-stage MDU control fields (start, MDUOp) and the forwarded operands.
- Models multi-cycle mult/div latency with a busy counter and owns the HI/LO registers.
- Supplies busy to the stall controller and drives the mfhi/mflo read value.
- Honours the exception flush request (req) so a flushed E-stage instruction never updates HI/LO.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1)

Ports:
- clk  input  1  pipeline clock
- reset  input  1  asynchronous, active-low reset
- req  input  1  exception/interrupt flush of the E stage this cycle
- start  input  1  E-stage instruction is mult/multu/div/divu
- MDUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, others none
- A  input  32  forwarded rs value
- B  input  32  forwarded rt value
- busy  output  1  multi-cycle operation in progress (registered)
- HI  output  32  HI register
- LO  output  32  LO register
- mdu_out  output  32  MDUOp==7 ? HI : LO (combinational, for mfhi/mflo)

Behaviour:
- Reset (reset==0, async): HI=0, LO=0, busy=0, counter=0, pending HI/LO=0. mdu_out then reads 0.
- Accept: start && !req && !busy && MDUOp in 1..4, sampled at posedge.
  - Compute the result at acceptance into pending_hi/pending_lo.
  - Load the counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4); busy=1 from the next cycle.
- mult: signed 64-bit A*B. multu: unsigned. {pending_hi, pending_lo} = product.
- div: signed. LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- divu: unsigned quotient/remainder.
- Divide by zero (B==0, ops 3,4):
  - Counter still runs; busy asserts the full DIV_CYCLES.
  - HI/LO are not updated at completion.
- Counting: each cycle with counter>0, the counter decrements. busy = (counter!=0), registered.
  - On the 1->0 transition edge, HI<=pending_hi, LO<=pending_lo, and busy falls on that same edge.
  - busy is high for exactly N cycles; new HI/LO are visible in the first cycle busy==0.
- mthi/mtlo (ops 5,6), when !req && !busy: HI<=A or LO<=A at the next edge.
  - Ignored while busy; the stall controller guarantees they are not issued then.
- req:
  - A start or mthi/mtlo in the same cycle as req is discarded: no HI/LO change, busy stays 0.
  - req while busy does not abort; the already-issued operation completes and writes HI/LO.
- start while busy is ignored. The stall controller must stall D on (busy || start) && D-stage MDU instruction; this block does not stall itself.
- MDUOp undefined values (0, 9–15) are no-ops.
- Reset mid-operation: counter, busy and pending results clear immediately; HI/LO return to 0.

Test Plan:
- Reset then release; mult A=0xFFFFFFFE (-2), B=3 with start=1 -> busy high exactly 5 cycles; first idle cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu A=7, B=0 -> busy 10 cycles, HI/LO unchanged.
- start with req=1 in the same cycle (mult 3*4) -> busy never asserts, HI/LO unchanged. Repeat with req at busy cycle 2 -> completes, LO=12.
- mtlo A=0x1234 then mfhi/mflo -> LO=0x1234 next cycle, mdu_out=0x1234 with MDUOp=8. mthi issued while busy -> HI unchanged.
- Assert reset at busy cycle 3 of a div -> busy=0, HI=LO=0 immediately, and no late write after reset release.
